// File: rtl/pipeline_debug_pkg.sv
// Command codes, dump framing constants and FSM encoding shared by the
// pipeline debug controller and its bench.
package pipeline_debug_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'
  localparam logic [7:0] CMD_FLUSH = 8'h46;  // 'F'

  localparam logic [7:0] DUMP_HEADER = 8'hA5;
  localparam int         DUMP_WORDS  = 34;   // 32 GPRs, PC, cycle count
  localparam int         NB_CYCLE    = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DUMP_HDR,
    ST_RD_WAIT,
    ST_SEND
  } dbg_state_e;

endpackage

// File: rtl/pipeline_debug_controller_if.sv
// Link, pipeline-control and debug-read signals of the debug controller.
// Names are seen from the controller: i_* flow in, o_* flow out.
interface pipeline_debug_controller_if #(
  parameter int NB_DATA           = 32,
  parameter int NB_ADDRESS        = 32,
  parameter int N_REGISTERS       = 32,
  parameter int NB_ADDR_REGISTERS = $clog2(N_REGISTERS),
  parameter int NB_BYTE           = 8
);

  logic [NB_BYTE-1:0]           i_rx_data;
  logic                         i_rx_valid;
  logic                         o_rx_ready;
  logic [NB_BYTE-1:0]           o_tx_data;
  logic                         o_tx_valid;
  logic                         i_tx_ready;
  logic                         o_pipe_en;
  logic                         o_pipe_flush;
  logic                         i_halt;
  logic [NB_ADDRESS-1:0]        i_pc;
  logic [NB_ADDR_REGISTERS-1:0] o_reg_addr;
  logic [NB_DATA-1:0]           i_reg_data;
  logic                         o_busy;

  modport slave (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_pc, i_reg_data,
    output o_rx_ready, o_tx_data, o_tx_valid, o_pipe_en, o_pipe_flush,
           o_reg_addr, o_busy
  );

  modport master (
    output i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_pc, i_reg_data,
    input  o_rx_ready, o_tx_data, o_tx_valid, o_pipe_en, o_pipe_flush,
           o_reg_addr, o_busy
  );

endinterface

// File: rtl/pipeline_debug_controller_serializer.sv
// Loads one word and streams its low nbytes_i bytes LSB first over a
// valid/ready byte link; the byte on tx_data_o holds until it is taken.
module debug_word_serializer #(
  parameter  int NB_DATA = 32,
  parameter  int NB_BYTE = 8,
  localparam int N_BYTES = NB_DATA / NB_BYTE,
  localparam int NB_CNT  = $clog2(N_BYTES + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [NB_DATA-1:0] word_i,
  input  logic [NB_CNT-1:0]  nbytes_i,
  output logic               busy_o,
  output logic [NB_BYTE-1:0] tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i
);

  logic [NB_DATA-1:0] shift_q;
  logic [NB_CNT-1:0]  left_q;

  assign busy_o     = (left_q != '0);
  assign tx_valid_o = busy_o;
  assign tx_data_o  = shift_q[NB_BYTE-1:0];

  // Loads are ignored while a word is still draining.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      left_q  <= '0;
    end else if (load_i && !busy_o) begin
      shift_q <= word_i;
      left_q  <= nbytes_i;
    end else if (busy_o && tx_ready_i) begin
      shift_q <= shift_q >> NB_BYTE;
      left_q  <= left_q - NB_CNT'(1);
    end
  end

endmodule

// File: rtl/pipeline_debug_controller.sv
// Byte-command debug sequencer: run/step/flush the pipeline through its
// clock-enable and stream a header + 34-word state dump back over the link.
module pipeline_debug_controller
  import pipeline_debug_pkg::*;
#(
  parameter int                  NB_DATA           = 32,
  parameter int                  NB_ADDRESS        = 32,
  parameter int                  N_REGISTERS       = 32,
  parameter int                  NB_ADDR_REGISTERS = $clog2(N_REGISTERS),
  parameter int                  NB_BYTE           = 8,
  parameter logic [NB_CYCLE-1:0] CYCLE_CNT_INIT    = '0
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  pipeline_debug_controller_if.slave  dbg
);

  localparam int N_WORDS = DUMP_WORDS;
  localparam int NB_IDX  = $clog2(N_WORDS);
  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT  = $clog2(N_BYTES + 1);

  dbg_state_e                   state_q, state_d;
  logic                         pipe_en_q, pipe_en_d;
  logic                         flush_q, flush_d;
  logic                         halted_q, halted_d;
  logic                         loaded_q, loaded_d;
  logic [NB_CYCLE-1:0]          cnt_q, cnt_d;
  logic [NB_CYCLE-1:0]          snap_q, snap_d;
  logic [NB_IDX-1:0]            idx_q, idx_d, idx_nxt;
  logic [NB_ADDR_REGISTERS-1:0] addr_q, addr_d;

  logic                         rx_fire;
  logic                         ser_load, ser_busy, tx_valid;
  logic [NB_DATA-1:0]           ser_word, slot_word;
  logic [NB_CNT-1:0]            ser_nbytes;
  logic [NB_BYTE-1:0]           tx_data;
  logic [NB_ADDRESS-1:0]        pc;

  assign rx_fire = dbg.i_rx_valid && (state_q == ST_IDLE);
  assign idx_nxt = idx_q + NB_IDX'(1);
  assign pc      = dbg.i_pc;

  // Slot contents: GPRs from the debug read port, then live PC, then the
  // cycle count captured when the frame started.
  always_comb begin
    if (idx_q < NB_IDX'(N_REGISTERS))       slot_word = dbg.i_reg_data;
    else if (idx_q == NB_IDX'(N_REGISTERS)) slot_word = NB_DATA'(pc);
    else                                    slot_word = NB_DATA'(snap_q);
  end

  always_comb begin
    state_d    = state_q;
    pipe_en_d  = 1'b0;
    flush_d    = 1'b0;
    halted_d   = halted_q;
    loaded_d   = loaded_q;
    cnt_d      = pipe_en_q ? cnt_q + NB_CYCLE'(1) : cnt_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    ser_load   = 1'b0;
    ser_word   = '0;
    ser_nbytes = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          case (dbg.i_rx_data)
            CMD_RUN: if (!halted_q) begin
              state_d   = ST_RUN;
              pipe_en_d = 1'b1;
            end
            CMD_STEP: if (!halted_q) begin
              state_d   = ST_STEP;
              pipe_en_d = 1'b1;
            end
            CMD_DUMP: state_d = ST_DUMP_HDR;
            CMD_FLUSH: begin
              flush_d  = 1'b1;
              cnt_d    = '0;
              halted_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (pipe_en_q && dbg.i_halt) begin
          halted_d = 1'b1;
          state_d  = ST_DUMP_HDR;
        end else begin
          pipe_en_d = 1'b1;
        end
      end
      ST_STEP: begin
        halted_d = halted_q | (pipe_en_q & dbg.i_halt);
        state_d  = ST_DUMP_HDR;
      end
      ST_DUMP_HDR: begin
        if (!ser_busy) begin
          ser_load   = 1'b1;
          ser_word   = NB_DATA'(DUMP_HEADER);
          ser_nbytes = NB_CNT'(1);
          snap_d     = cnt_q;
          idx_d      = '0;
          addr_d     = '0;
          state_d    = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        loaded_d = 1'b0;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        // The read address stays put, so the word is still valid if the
        // header or previous word is slow to drain.
        if (!loaded_q) begin
          if (!ser_busy) begin
            ser_load   = 1'b1;
            ser_word   = slot_word;
            ser_nbytes = NB_CNT'(N_BYTES);
            loaded_d   = 1'b1;
          end
        end else if (!ser_busy) begin
          if (idx_q == NB_IDX'(N_WORDS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_nxt;
            addr_d  = idx_nxt[NB_ADDR_REGISTERS-1:0];
            state_d = ST_RD_WAIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      pipe_en_q <= 1'b0;
      flush_q   <= 1'b0;
      halted_q  <= 1'b0;
      loaded_q  <= 1'b0;
      cnt_q     <= CYCLE_CNT_INIT;
      snap_q    <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      pipe_en_q <= pipe_en_d;
      flush_q   <= flush_d;
      halted_q  <= halted_d;
      loaded_q  <= loaded_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
    end
  end

  debug_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .clk_i      (i_clk),
    .rst_ni     (i_reset_n),
    .load_i     (ser_load),
    .word_i     (ser_word),
    .nbytes_i   (ser_nbytes),
    .busy_o     (ser_busy),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (dbg.i_tx_ready)
  );

  assign dbg.o_rx_ready   = (state_q == ST_IDLE);
  assign dbg.o_busy       = (state_q != ST_IDLE);
  assign dbg.o_pipe_en    = pipe_en_q;
  assign dbg.o_pipe_flush = flush_q;
  assign dbg.o_reg_addr   = addr_q;
  assign dbg.o_tx_data    = tx_data;
  assign dbg.o_tx_valid   = tx_valid;

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Scoreboarded bench: expected dump bytes are queued when a command is sent
// and popped as the controller hands bytes over the TX link.
module tb_pipeline_debug_controller;
  import pipeline_debug_pkg::*;

  localparam logic [31:0] PC_VAL    = 32'h0000_1000;
  localparam int          FRAME_LEN = 1 + 4 * DUMP_WORDS;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int         tests = 0, fails = 0;
  int         byte_cnt = 0, pe_cnt = 0, fl_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got2[$];
  bit         bp_rand = 1'b0;
  bit         stall_q = 1'b0;
  logic [7:0] stall_data = '0;

  pipeline_debug_controller_if ifc ();
  pipeline_debug_controller_if ifc2 ();

  pipeline_debug_controller dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .dbg       (ifc)
  );

  pipeline_debug_controller #(.CYCLE_CNT_INIT(32'hFFFF_FFFF)) dut_wrap (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .dbg       (ifc2)
  );

  function automatic logic [31:0] gpr(input logic [4:0] n);
    return 32'h1111_0000 + {27'd0, n};
  endfunction

  // Register file with a one-cycle read latency.
  always @(posedge clk) begin
    ifc.i_reg_data  <= gpr(ifc.o_reg_addr);
    ifc2.i_reg_data <= gpr(ifc2.o_reg_addr);
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (stall_q) begin
        tests++;
        if (ifc.o_tx_valid !== 1'b1 || ifc.o_tx_data !== stall_data) begin
          fails++;
          $display("FAIL tx_hold: valid=%b data=%h, required valid=1 data=%h",
                   ifc.o_tx_valid, ifc.o_tx_data, stall_data);
        end
      end
      ifc.i_tx_ready = bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      stall_q    = ifc.o_tx_valid && !ifc.i_tx_ready;
      stall_data = ifc.o_tx_data;
      if (ifc.o_pipe_en)    pe_cnt++;
      if (ifc.o_pipe_flush) fl_cnt++;
      if (ifc.o_tx_valid && ifc.i_tx_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL tx_extra: got byte %h, required no byte", ifc.o_tx_data);
        end else begin
          e = exp_q.pop_front();
          if (ifc.o_tx_data !== e) begin
            fails++;
            $display("FAIL tx_byte[%0d]: got %h, required %h", byte_cnt, ifc.o_tx_data, e);
          end
        end
        byte_cnt++;
      end
    end else begin
      stall_q = 1'b0;
    end
  end

  always @(negedge clk)
    if (rst_n && ifc2.o_tx_valid && ifc2.i_tx_ready) got2.push_back(ifc2.o_tx_data);

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_frame(input logic [31:0] cnt, input logic [31:0] pc);
    logic [31:0] w;
    exp_q.push_back(DUMP_HEADER);
    for (int i = 0; i < DUMP_WORDS; i++) begin
      w = (i < 32) ? gpr(5'(i)) : (i == 32) ? pc : cnt;
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk);
    ifc.i_rx_data  = c;
    ifc.i_rx_valid = 1'b1;
    tests++;
    if (ifc.o_rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL cmd_ready: cmd %h saw rx_ready=%b, required 1", c, ifc.o_rx_ready);
    end
    @(negedge clk);
    ifc.i_rx_valid = 1'b0;
    ifc.i_rx_data  = '0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || ifc.o_busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k >= 3000) begin
      fails++;
      $display("FAIL %s_done: %0d bytes pending busy=%b, required 0 pending and idle",
               name, exp_q.size(), ifc.o_busy);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    tests++;
    if ({ifc.o_pipe_en, ifc.o_pipe_flush, ifc.o_tx_valid, ifc.o_busy} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctl: en/flush/txv/busy=%b, required 0000",
               {ifc.o_pipe_en, ifc.o_pipe_flush, ifc.o_tx_valid, ifc.o_busy});
    end
    tests++;
    if (ifc.o_tx_data !== 8'h00 || ifc.o_reg_addr !== 5'd0) begin
      fails++;
      $display("FAIL reset_data: tx_data=%h reg_addr=%h, required 00/00", ifc.o_tx_data, ifc.o_reg_addr);
    end
    tests++;
    if (ifc.o_rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_rdy: rx_ready=%b, required 1", ifc.o_rx_ready);
    end
    cycles(2);
    #1 rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_step();
    int pe0 = pe_cnt;
    push_frame(32'd1, PC_VAL);
    send_cmd(CMD_STEP);
    wait_done("step");
    tests++;
    if (pe_cnt - pe0 !== 1) begin
      fails++;
      $display("FAIL step_en: %0d enabled cycles, required 1", pe_cnt - pe0);
    end
  endtask

  task automatic test_run_halt();
    int n = 0, k = 0;
    send_cmd(CMD_FLUSH);
    cycles(2);
    push_frame(32'd10, PC_VAL);
    send_cmd(CMD_RUN);
    while (n < 10 && k < 200) begin
      if (ifc.o_pipe_en) n++;
      if (n < 10) begin
        @(negedge clk);
        k++;
      end
    end
    ifc.i_halt = 1'b1;
    @(negedge clk);
    ifc.i_halt = 1'b0;
    tests++;
    if (n !== 10) begin
      fails++;
      $display("FAIL run_cycles: %0d enabled cycles seen, required 10", n);
    end
    tests++;
    if (ifc.o_pipe_en !== 1'b0) begin
      fails++;
      $display("FAIL run_stop: pipe_en=%b after halt, required 0", ifc.o_pipe_en);
    end
    wait_done("run");
  endtask

  task automatic test_halted();
    int pe0 = pe_cnt, fl0;
    send_cmd(CMD_RUN);
    cycles(4);
    send_cmd(CMD_STEP);
    cycles(4);
    tests++;
    if (pe_cnt - pe0 !== 0 || ifc.o_busy !== 1'b0) begin
      fails++;
      $display("FAIL halted_ignore: %0d enabled cycles busy=%b, required 0/0", pe_cnt - pe0, ifc.o_busy);
    end
    fl0 = fl_cnt;
    send_cmd(CMD_FLUSH);
    cycles(4);
    tests++;
    if (fl_cnt - fl0 !== 1) begin
      fails++;
      $display("FAIL flush_pulse: %0d flush cycles, required 1", fl_cnt - fl0);
    end
    pe0 = pe_cnt;
    push_frame(32'd1, PC_VAL);
    send_cmd(CMD_STEP);
    wait_done("step_after_flush");
    tests++;
    if (pe_cnt - pe0 !== 1) begin
      fails++;
      $display("FAIL step_after_flush: %0d enabled cycles, required 1", pe_cnt - pe0);
    end
  endtask

  task automatic test_backpressure();
    int pe0 = pe_cnt;
    bp_rand    = 1'b1;
    ifc.i_halt = 1'b1;  // not an enabled cycle: must not set halted
    push_frame(32'd1, PC_VAL);
    send_cmd(CMD_DUMP);
    wait_done("bp_dump");
    bp_rand    = 1'b0;
    ifc.i_halt = 1'b0;
    tests++;
    if (pe_cnt - pe0 !== 0) begin
      fails++;
      $display("FAIL dump_en: %0d enabled cycles, required 0", pe_cnt - pe0);
    end
    pe0 = pe_cnt;
    push_frame(32'd2, PC_VAL);
    send_cmd(CMD_STEP);
    wait_done("step2");
    tests++;
    if (pe_cnt - pe0 !== 1) begin
      fails++;
      $display("FAIL step2_en: %0d enabled cycles, required 1", pe_cnt - pe0);
    end
  endtask

  task automatic test_reset_mid_dump();
    int b0 = byte_cnt, b1, k = 0;
    push_frame(32'd2, PC_VAL);
    send_cmd(CMD_DUMP);
    while (byte_cnt - b0 < 50 && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (k >= 1000) begin
      fails++;
      $display("FAIL mid_reach: %0d bytes before timeout, required 50", byte_cnt - b0);
    end
    tests++;
    if ({ifc.o_pipe_en, ifc.o_pipe_flush, ifc.o_tx_valid, ifc.o_tx_data, ifc.o_reg_addr} !== 16'h0) begin
      fails++;
      $display("FAIL mid_reset_out: en=%b fl=%b txv=%b txd=%h addr=%h, required all 0",
               ifc.o_pipe_en, ifc.o_pipe_flush, ifc.o_tx_valid, ifc.o_tx_data, ifc.o_reg_addr);
    end
    exp_q.delete();
    cycles(3);
    #1 rst_n = 1'b1;
    b1 = byte_cnt;
    cycles(200);
    tests++;
    if (byte_cnt !== b1 || ifc.o_rx_ready !== 1'b1 || ifc.o_busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_after: %0d extra bytes rdy=%b busy=%b, required 0/1/0",
               byte_cnt - b1, ifc.o_rx_ready, ifc.o_busy);
    end
  endtask

  task automatic grab2(input logic [7:0] c, output logic [31:0] cnt, output logic [7:0] hdr, output int len);
    int k = 0;
    got2.delete();
    @(negedge clk);
    ifc2.i_rx_data  = c;
    ifc2.i_rx_valid = 1'b1;
    @(negedge clk);
    ifc2.i_rx_valid = 1'b0;
    while ((got2.size() < FRAME_LEN || ifc2.o_busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    len = got2.size();
    cnt = '0;
    hdr = '0;
    if (len >= FRAME_LEN) begin
      hdr = got2[0];
      cnt = {got2[FRAME_LEN-1], got2[FRAME_LEN-2], got2[FRAME_LEN-3], got2[FRAME_LEN-4]};
    end
  endtask

  task automatic test_wrap();
    logic [31:0] cnt;
    logic [7:0]  hdr;
    int          len;
    grab2(CMD_DUMP, cnt, hdr, len);
    tests++;
    if (len !== FRAME_LEN || hdr !== 8'hA5 || cnt !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL wrap_pre: len=%0d hdr=%h cnt=%h, required %0d/a5/ffffffff", len, hdr, cnt, FRAME_LEN);
    end
    grab2(CMD_STEP, cnt, hdr, len);
    tests++;
    if (len !== FRAME_LEN || hdr !== 8'hA5 || cnt !== 32'h0000_0000) begin
      fails++;
      $display("FAIL wrap_post: len=%0d hdr=%h cnt=%h, required %0d/a5/00000000", len, hdr, cnt, FRAME_LEN);
    end
  endtask

  initial begin
    ifc.i_rx_data   = '0;
    ifc.i_rx_valid  = 1'b0;
    ifc.i_tx_ready  = 1'b1;
    ifc.i_halt      = 1'b0;
    ifc.i_pc        = PC_VAL;
    ifc2.i_rx_data  = '0;
    ifc2.i_rx_valid = 1'b0;
    ifc2.i_tx_ready = 1'b1;
    ifc2.i_halt     = 1'b0;
    ifc2.i_pc       = '0;
    test_reset();
    test_step();
    test_run_halt();
    test_halted();
    test_backpressure();
    test_reset_mid_dump();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
